// File: rtl/flash_seq_pkg.sv
// Shared types and timing defaults for the flash access sequencer.
package flash_seq_pkg;

    typedef enum logic [2:0] {StIdle, StRd, StWs, StWp, StWh} state_e;

    typedef enum logic [1:0] {OpAddr, OpWdata, OpRdata} op_e;

    localparam int unsigned DefAddrW   = 19;
    localparam int unsigned DefRdCyc   = 4;
    localparam int unsigned DefWrSetup = 2;
    localparam int unsigned DefWrPulse = 4;
    localparam int unsigned DefWrHold  = 2;
    localparam int unsigned CntW       = 4;

    // A phase of N clocks counts N-1 down to 0.
    function automatic logic [CntW-1:0] cnt_load(input int unsigned cycles);
        return CntW'(cycles - 1);
    endfunction

endpackage

// File: rtl/flash_cyc_timer.sv
// Loadable 4-bit down-counter shared by every timed sequencer state.
module flash_cyc_timer
    import flash_seq_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    input  logic            load,
    input  logic [CntW-1:0] load_val,
    output logic            done
);

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/flash_seq.sv
// Flash access sequencer: address register, pending slot, timed read/write cycles
// and a prefetched read byte that always mirrors flash[addr] when idle.
module flash_seq
    import flash_seq_pkg::*;
#(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned RD_CYC   = DefRdCyc,
    parameter int unsigned WR_SETUP = DefWrSetup,
    parameter int unsigned WR_PULSE = DefWrPulse,
    parameter int unsigned WR_HOLD  = DefWrHold
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              wr_addr,
    input  logic              wr_data,
    input  logic              rd_data,
    input  logic [7:0]        wr_buffer,
    output logic [7:0]        rd_buffer,
    output logic              busy,
    output logic              overrun,
    output logic [ADDR_W-1:0] flash_a,
    inout  wire  [7:0]        flash_d,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic              flash_we_n
);

    state_e            state;
    logic              rd_setup;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dout;
    logic              d_oe;
    logic              slot_valid;
    op_e               slot_op;
    logic [7:0]        slot_byte;

    logic              any_strobe;
    logic              multi_strobe;
    op_e               win_op;
    logic              go;
    op_e               go_op;
    logic [7:0]        go_byte;
    logic              rd_last;
    logic              busy_nxt;
    logic              tmr_load;
    logic [CntW-1:0]   tmr_val;
    logic              done;

    assign any_strobe   = wr_addr | wr_data | rd_data;
    assign multi_strobe = (wr_addr & wr_data) | (wr_addr & rd_data) | (wr_data & rd_data);

    always_comb begin
        win_op = OpRdata;
        if (wr_addr) begin
            win_op = OpAddr;
        end else if (wr_data) begin
            win_op = OpWdata;
        end
    end

    // A queued op always runs before a fresh strobe.
    assign go      = (state == StIdle) && (slot_valid || any_strobe);
    assign go_op   = slot_valid ? slot_op : win_op;
    assign go_byte = slot_valid ? slot_byte : wr_buffer;
    assign rd_last = (state == StRd) && !rd_setup && done;

    assign busy_nxt = !((state == StIdle) || rd_last) || slot_valid || any_strobe;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            StIdle: if (go && go_op == OpWdata) begin
                tmr_load = 1'b1;
                tmr_val  = cnt_load(WR_SETUP);
            end
            StRd: if (rd_setup) begin
                tmr_load = 1'b1;
                tmr_val  = cnt_load(RD_CYC);
            end
            StWs: if (done) begin
                tmr_load = 1'b1;
                tmr_val  = cnt_load(WR_PULSE);
            end
            StWp: if (done) begin
                tmr_load = 1'b1;
                tmr_val  = cnt_load(WR_HOLD);
            end
            default: ;
        endcase
    end

    flash_cyc_timer u_timer (
        .clk      (clk),
        .clr      (rst | init),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (done)
    );

    always_ff @(posedge clk) begin
        if (rst || init) begin
            state      <= StIdle;
            rd_setup   <= 1'b0;
            addr       <= '0;
            rd_buffer  <= 8'hFF;
            dout       <= 8'h00;
            d_oe       <= 1'b0;
            flash_ce_n <= 1'b1;
            flash_oe_n <= 1'b1;
            flash_we_n <= 1'b1;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            slot_valid <= 1'b0;
            slot_op    <= OpAddr;
            slot_byte  <= 8'h00;
        end else begin
            busy <= busy_nxt;
            if (multi_strobe) begin
                overrun <= 1'b1;
            end

            // In IDLE a full slot is drained this clock, so a new strobe can refill it.
            if (state == StIdle) begin
                if (slot_valid) begin
                    slot_valid <= any_strobe;
                    slot_op    <= win_op;
                    slot_byte  <= wr_buffer;
                end
            end else if (any_strobe) begin
                if (slot_valid) begin
                    overrun <= 1'b1;
                end else begin
                    slot_valid <= 1'b1;
                    slot_op    <= win_op;
                    slot_byte  <= wr_buffer;
                end
            end

            unique case (state)
                StIdle: begin
                    if (go) begin
                        flash_ce_n <= 1'b0;
                        case (go_op)
                            OpAddr: begin
                                addr     <= {addr[ADDR_W-9:0], go_byte};
                                state    <= StRd;
                                rd_setup <= 1'b1;
                            end
                            OpWdata: begin
                                dout  <= go_byte;
                                d_oe  <= 1'b1;
                                state <= StWs;
                            end
                            default: begin
                                addr     <= addr + ADDR_W'(1);
                                state    <= StRd;
                                rd_setup <= 1'b1;
                            end
                        endcase
                    end
                end
                StRd: begin
                    // First RD clock is address setup with oe_n still high.
                    if (rd_setup) begin
                        rd_setup   <= 1'b0;
                        flash_oe_n <= 1'b0;
                    end else if (done) begin
                        rd_buffer  <= flash_d;
                        flash_oe_n <= 1'b1;
                        flash_ce_n <= 1'b1;
                        state      <= StIdle;
                    end
                end
                StWs: begin
                    if (done) begin
                        flash_we_n <= 1'b0;
                        state      <= StWp;
                    end
                end
                StWp: begin
                    if (done) begin
                        flash_we_n <= 1'b1;
                        state      <= StWh;
                    end
                end
                StWh: begin
                    if (done) begin
                        d_oe     <= 1'b0;
                        addr     <= addr + ADDR_W'(1);
                        state    <= StRd;
                        rd_setup <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign flash_a = addr;
    assign flash_d = d_oe ? dout : 8'bz;

endmodule

// File: tb/tb_flash_seq.sv
// Directed bench for flash_seq with a simple flash read model on the data bus.
module tb_flash_seq;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init = 1'b0;
    logic          wr_addr = 1'b0;
    logic          wr_data = 1'b0;
    logic          rd_data = 1'b0;
    logic [7:0]    wr_buffer = 8'h00;
    logic [7:0]    rd_buffer;
    logic          busy;
    logic          overrun;
    logic [AW-1:0] flash_a;
    wire  [7:0]    flash_d;
    logic          flash_ce_n;
    logic          flash_oe_n;
    logic          flash_we_n;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [7:0]    mem_rd;

    int total = 0;
    int bad = 0;

    flash_seq dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .wr_buffer  (wr_buffer),
        .rd_buffer  (rd_buffer),
        .busy       (busy),
        .overrun    (overrun),
        .flash_a    (flash_a),
        .flash_d    (flash_d),
        .flash_ce_n (flash_ce_n),
        .flash_oe_n (flash_oe_n),
        .flash_we_n (flash_we_n)
    );

    always #5 clk = ~clk;

    assign mem_rd  = mem[flash_a];
    assign flash_d = (!flash_ce_n && !flash_oe_n) ? mem_rd : 8'bz;

    // Released bus floats high so "not driven" reads as 8'hFF.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (flash_d[g]);
    end

    // kind: 0 = wr_addr, 1 = wr_data, 2 = rd_data
    task automatic strobe(input int kind, input logic [7:0] b);
        @(negedge clk);
        wr_buffer = b;
        wr_addr   = (kind == 0);
        wr_data   = (kind == 1);
        rd_data   = (kind == 2);
        @(negedge clk);
        wr_addr = 1'b0;
        wr_data = 1'b0;
        rd_data = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL %s_timeout: busy=%b after %0d clocks, want 0", name, busy, n);
        end
    endtask

    task automatic load_addr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        strobe(0, b0);
        wait_idle("load0");
        strobe(0, b1);
        wait_idle("load1");
        strobe(0, b2);
        wait_idle("load2");
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++;
        if (flash_a !== 19'h0) begin
            bad++; $display("FAIL reset_addr: got %h want 00000", flash_a);
        end
        total++;
        if ({flash_ce_n, flash_oe_n, flash_we_n} !== 3'b111) begin
            bad++; $display("FAIL reset_ctl: got %b want 111", {flash_ce_n, flash_oe_n, flash_we_n});
        end
        total++;
        if (rd_buffer !== 8'hFF) begin
            bad++; $display("FAIL reset_rdbuf: got %h want ff", rd_buffer);
        end
        total++;
        if ({busy, overrun} !== 2'b00) begin
            bad++; $display("FAIL reset_flags: busy/overrun got %b want 00", {busy, overrun});
        end
        total++;
        if (flash_d !== 8'hFF) begin
            bad++; $display("FAIL reset_bus: flash_d got %h want released (ff)", flash_d);
        end
        @(negedge clk);
        total++;
        if ({busy, flash_oe_n} !== 2'b01) begin
            bad++; $display("FAIL reset_noprefetch: busy/oe_n got %b want 01", {busy, flash_oe_n});
        end
    endtask

    task automatic test_addr_load;
        strobe(0, 8'h01);
        total++;
        if ({busy, flash_ce_n, flash_oe_n, flash_we_n} !== 4'b1011 || flash_a !== 19'h00001) begin
            bad++;
            $display("FAIL addr_first_clock: busy/ce/oe/we=%b a=%h want 1011 a=00001",
                     {busy, flash_ce_n, flash_oe_n, flash_we_n}, flash_a);
        end
        wait_idle("addr0");
        total++;
        if (rd_buffer !== 8'h5D) begin
            bad++; $display("FAIL addr_prefetch1: got %h want 5d", rd_buffer);
        end
        strobe(0, 8'h23);
        wait_idle("addr1");
        strobe(0, 8'h45);
        wait_idle("addr2");
        total++;
        if (flash_a !== 19'h12345) begin
            bad++; $display("FAIL addr_full: got %h want 12345", flash_a);
        end
        total++;
        if (rd_buffer !== 8'hA5 || busy !== 1'b0) begin
            bad++; $display("FAIL addr_rdbuf: got %h busy=%b want a5 busy=0", rd_buffer, busy);
        end
    endtask

    task automatic test_seq_read;
        int n = 0;
        int oe_cnt = 0;
        int a_bad = 0;
        int rb_bad = 0;
        strobe(2, 8'h00);
        while (busy && n < 50) begin
            if (!flash_oe_n) begin
                oe_cnt++;
                if (flash_a !== 19'h12346) a_bad++;
                if (rd_buffer !== 8'hA5) rb_bad++;
            end
            @(negedge clk);
            n++;
        end
        total++;
        if (busy) begin
            bad++; $display("FAIL read_timeout: busy stuck after %0d clocks", n);
        end
        total++;
        if (oe_cnt != 4) begin
            bad++; $display("FAIL read_oe_len: got %0d clocks want 4", oe_cnt);
        end
        total++;
        if (a_bad != 0 || rb_bad != 0) begin
            bad++; $display("FAIL read_stable: addr_glitches=%0d rdbuf_early=%0d want 0/0", a_bad, rb_bad);
        end
        total++;
        if (flash_a !== 19'h12346 || rd_buffer !== 8'h5A) begin
            bad++; $display("FAIL read_result: a=%h rd=%h want 12346/5a", flash_a, rd_buffer);
        end
    endtask

    task automatic test_write;
        int n = 0;
        int setup = 0;
        int pulse = 0;
        int hold = 0;
        int oe_cnt = 0;
        int ad_bad = 0;
        load_addr(8'h00, 8'h01, 8'h00);
        total++;
        if (flash_a !== 19'h00100) begin
            bad++; $display("FAIL write_addr: got %h want 00100", flash_a);
        end
        strobe(1, 8'h3C);
        while (busy && n < 60) begin
            if (!flash_we_n) begin
                pulse++;
                if (flash_a !== 19'h00100 || flash_d !== 8'h3C) ad_bad++;
            end else if (!flash_ce_n && flash_oe_n && flash_d === 8'h3C) begin
                if (pulse == 0) setup++;
                else hold++;
                if (flash_a !== 19'h00100) ad_bad++;
            end else if (!flash_oe_n) begin
                oe_cnt++;
                if (flash_a !== 19'h00101) ad_bad++;
            end
            @(negedge clk);
            n++;
        end
        total++;
        if (setup != 2 || pulse != 4 || hold != 2) begin
            bad++;
            $display("FAIL write_phases: setup/pulse/hold got %0d/%0d/%0d want 2/4/2", setup, pulse, hold);
        end
        total++;
        if (oe_cnt != 4 || n != 13) begin
            bad++; $display("FAIL write_length: oe=%0d busy=%0d want 4/13", oe_cnt, n);
        end
        total++;
        if (ad_bad != 0) begin
            bad++; $display("FAIL write_stable: %0d bad addr/data samples want 0", ad_bad);
        end
        total++;
        if (flash_a !== 19'h00101 || rd_buffer !== 8'h5D) begin
            bad++; $display("FAIL write_prefetch: a=%h rd=%h want 00101/5d", flash_a, rd_buffer);
        end
    endtask

    task automatic test_wrap;
        load_addr(8'h07, 8'hFF, 8'hFF);
        total++;
        if (flash_a !== 19'h7FFFF || rd_buffer !== 8'hA3) begin
            bad++; $display("FAIL wrap_top: a=%h rd=%h want 7ffff/a3", flash_a, rd_buffer);
        end
        strobe(2, 8'h00);
        wait_idle("wrap");
        total++;
        if (flash_a !== 19'h00000 || rd_buffer !== 8'h77) begin
            bad++; $display("FAIL wrap_zero: a=%h rd=%h want 00000/77", flash_a, rd_buffer);
        end
    endtask

    task automatic test_pending;
        strobe(2, 8'h00);
        @(negedge clk);
        strobe(2, 8'h00);
        total++;
        if ({busy, overrun} !== 2'b10) begin
            bad++; $display("FAIL pend_queue: busy/overrun got %b want 10", {busy, overrun});
        end
        wait_idle("pend");
        total++;
        if (flash_a !== 19'h00002 || rd_buffer !== 8'h5E || overrun !== 1'b0) begin
            bad++;
            $display("FAIL pend_result: a=%h rd=%h ovr=%b want 00002/5e/0", flash_a, rd_buffer, overrun);
        end
        @(negedge clk);
        rd_data = 1'b1;
        repeat (3) @(negedge clk);
        rd_data = 1'b0;
        wait_idle("overrun");
        total++;
        if (flash_a !== 19'h00004 || rd_buffer !== 8'h58 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_drop: a=%h rd=%h ovr=%b want 00004/58/1", flash_a, rd_buffer, overrun);
        end
    endtask

    task automatic test_init_mid_write;
        int n = 0;
        strobe(1, 8'h99);
        while (flash_we_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (flash_we_n) begin
            bad++; $display("FAIL init_reach_wp: we_n stayed %b, want 0", flash_we_n);
        end
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        total++;
        if ({flash_ce_n, flash_oe_n, flash_we_n} !== 3'b111 || flash_d !== 8'hFF) begin
            bad++;
            $display("FAIL init_bus: ctl=%b d=%h want 111/ff", {flash_ce_n, flash_oe_n, flash_we_n}, flash_d);
        end
        total++;
        if (flash_a !== 19'h0 || rd_buffer !== 8'hFF || {busy, overrun} !== 2'b00) begin
            bad++;
            $display("FAIL init_state: a=%h rd=%h busy/ovr=%b want 00000/ff/00",
                     flash_a, rd_buffer, {busy, overrun});
        end
        @(negedge clk);
        total++;
        if ({busy, flash_ce_n, flash_oe_n} !== 3'b011) begin
            bad++; $display("FAIL init_noprefetch: busy/ce/oe got %b want 011", {busy, flash_ce_n, flash_oe_n});
        end
    endtask

    task automatic test_simultaneous;
        @(negedge clk);
        wr_buffer = 8'h09;
        wr_addr   = 1'b1;
        rd_data   = 1'b1;
        @(negedge clk);
        wr_addr = 1'b0;
        rd_data = 1'b0;
        wait_idle("simul");
        total++;
        if (flash_a !== 19'h00009 || rd_buffer !== 8'h55 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL simul_priority: a=%h rd=%h ovr=%b want 00009/55/1", flash_a, rd_buffer, overrun);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 8'(i) ^ 8'h5C;
        end
        mem[19'h00000] = 8'h77;
        mem[19'h12345] = 8'hA5;
        mem[19'h12346] = 8'h5A;

        test_reset();
        test_addr_load();
        test_seq_read();
        test_write();
        test_wrap();
        test_pending();
        test_init_mid_write();
        test_simultaneous();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flash_seq.md
# flash_seq

Flash access sequencer for the NeoGS flash programmer. It sits between the zxbus controller's strobes (`wr_addr`, `wr_data`, `rd_data`, `wr_buffer`) and the parallel flash chip. It owns the flash address register and auto-increments it, and it runs timed read and write bus cycles. It keeps `rd_buffer` pre-fetched so that every ZX read of port BB returns immediately.

## Interface
Parameters:
- `ADDR_W`, 19: flash address width (512 KB).
- `RD_CYC`, 4: clocks with `flash_oe_n` low before data is sampled (1..15).
- `WR_SETUP`, 2: clocks of address/data setup before `flash_we_n` falls (1..15).
- `WR_PULSE`, 4: clocks with `flash_we_n` low (1..15).
- `WR_HOLD`, 2: clocks of address/data hold after `flash_we_n` rises (1..15).

Ports:
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `init` in 1: one-clock pulse. Aborts the current cycle and clears all state, same as `rst`.
- `wr_addr` in 1: one-clock strobe, address byte write.
- `wr_data` in 1: one-clock strobe, data byte write to flash.
- `rd_data` in 1: one-clock strobe, data byte consumed by the ZX.
- `wr_buffer` in 8: byte accompanying `wr_addr` / `wr_data`.
- `rd_buffer` out 8: pre-fetched byte at the current address.
- `busy` out 1: high while a cycle is running or one is pending.
- `overrun` out 1: sticky; set when a strobe is dropped. Cleared by `rst`/`init`.
- `flash_a` out ADDR_W: flash address.
- `flash_d` inout 8: flash data. Driven only during write cycles, otherwise Z.
- `flash_ce_n`, `flash_oe_n`, `flash_we_n` out 1 each: flash controls, active low.

## Operation
- Address register `addr` is ADDR_W bits and wraps from all-ones to 0.
- **Ops.** Every op ends with a prefetch, so `rd_buffer` equals `flash[addr]` when the sequencer returns to IDLE.
  - Address write: `addr <= {addr[ADDR_W-9:0], wr_buffer}`, then prefetch. Three writes load a full 19-bit address, most significant byte first.
  - Data write: write cycle of `wr_buffer` at `addr`, then `addr <= addr+1`, then prefetch.
  - Data read: `addr <= addr+1`, then prefetch. The byte already in `rd_buffer` was returned to the ZX in the same strobe cycle.
- **States:**
  - IDLE: all control lines high.
  - RD: `ce_n`=0, `oe_n`=0 for RD_CYC clocks. On the last clock, `flash_d` is latched into `rd_buffer`. Then go to IDLE.
  - WS: `ce_n`=0, data driven, WR_SETUP clocks.
  - WP: `we_n`=0, WR_PULSE clocks.
  - WH: `we_n`=1, data still driven, WR_HOLD clocks. Then `addr++` and go to RD.
- **Pending slot (1 entry: op type + byte).**
  - A strobe arriving while not IDLE is stored in the slot.
  - A strobe arriving while the slot is full is dropped and sets `overrun`.
  - On entering IDLE with the slot full, the stored op starts on the next clock.
- **Simultaneous strobes** in one clock (cannot occur from zxbus): priority is `wr_addr` > `wr_data` > `rd_data`. The losers are dropped and set `overrun`.
- **`rst`/`init` mid-cycle:**
  - Next clock: all controls high, `flash_d` Z, state IDLE.
  - `addr`=0, `rd_buffer`=0xFF, slot empty, `busy`=0, `overrun`=0.
  - No prefetch is issued after reset.

## Timing
- **Reset values:** `flash_a`=0, `ce_n`/`oe_n`/`we_n`=1, `flash_d`=Z, `rd_buffer`=8'hFF, `busy`=0, `overrun`=0.
- **Strobe in IDLE at clock T:** `busy`=1 and the first active state at T+1. All outputs are registered.
- **Read cycle:** RD_CYC clocks. `flash_a` is stable from the clock before `oe_n` falls until `oe_n` rises.
- **`rd_buffer` update:** changes only on the last RD clock. Otherwise it holds.
- **Write op length:** WR_SETUP + WR_PULSE + WR_HOLD + RD_CYC clocks, plus one clock for the `addr` update.
- **`flash_a` / `flash_d` stability:** both stay constant from the start of WS to the end of WH.
- **`busy`:** falls on the clock IDLE is re-entered with the slot empty.
- **Counter:** 4-bit down-counter, loaded with (parameter − 1) on state entry. The state advances at 0.

## Structure
- Package `flash_seq_pkg`:
  - State encoding (IDLE, RD, WS, WP, WH).
  - Op-type codes (OP_ADDR, OP_WDATA, OP_RDATA).
  - Default timing constants.
- One sub-module, `flash_cyc_timer`: loadable 4-bit down-counter with a `done` output. It is shared by all timed states.
- The FSM, address register and pending slot live in `flash_seq`.

## Test plan
- **Address load and prefetch.** Model flash[0x12345]=0xA5. Strobe `wr_addr` with 0x01, 0x23, 0x45. Expect `flash_a`=0x12345, then `rd_buffer`=0xA5, then `busy`=0.
- **Sequential read.** Model flash[0x12346]=0x5A. Strobe `rd_data`. Expect `addr` 0x12346, `rd_buffer`=0x5A, and `oe_n` low for exactly 4 clocks.
- **Write cycle.** Strobe `wr_data` with 0x3C at addr 0x00100. Check:
  - `flash_d`=0x3C and `flash_a`=0x00100 through WS/WP/WH.
  - `we_n` low for exactly 4 clocks, with 2 clocks of setup and 2 clocks of hold.
  - Then a prefetch at 0x00101.
- **Wrap-around.** Load addr 0x7FFFF, then strobe `rd_data`. Expect `flash_a`=0x00000 and `rd_buffer`=flash[0].
- **Pending slot and overrun.** Strobe `rd_data` mid-read: it executes after the current op and `overrun` stays 0. A third strobe while the slot is full is dropped and `overrun`=1.
- **Init mid-write.** Pulse `init` during WP. Next clock: `we_n`=1, `flash_d`=Z, `addr`=0, `rd_buffer`=0xFF, `busy`=0, `overrun`=0.
